// File: rtl/counter_cmd_responder_pkg.sv
// ---------------------------------------------------------------------------
// counter_cmd_pkg
// Shared types for the counter command protocol. The responder RTL, the
// interface, the DPI-side driver and the checker all import this package, so
// the op-code encoding and FSM state names live in exactly one place.
//   cmd_op_e : 2-bit command op code (RESET / LOAD / CYCLE / GET)
//   state_e  : responder FSM state (IDLE accepting commands, RESP holding a
//              GET response until it is consumed)
// ---------------------------------------------------------------------------
package counter_cmd_pkg;

   // The encoding matches the C model's command numbering, so it must not be
   // reordered.
   typedef enum logic [1:0] {
      CMD_RESET = 2'd0,
      CMD_LOAD  = 2'd1,
      CMD_CYCLE = 2'd2,
      CMD_GET   = 2'd3
   } cmd_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_e;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/counter_cmd_responder_if.sv
// ---------------------------------------------------------------------------
// counter_cmd_responder_if
// Command and response channels of the counter command protocol, each one a
// valid/ready pair.
//   cmd_valid / cmd_ready / cmd_op / cmd_data : command channel (master -> slave)
//   rsp_valid / rsp_ready / rsp_data          : response channel (slave -> master)
// Modports:
//   master : the side that issues commands and consumes responses
//   slave  : the responder
// ---------------------------------------------------------------------------
interface counter_cmd_responder_if #(
   parameter int WIDTH = counter_cmd_pkg::DEFAULT_WIDTH
);
   import counter_cmd_pkg::*;

   logic             cmd_valid;
   logic             cmd_ready;
   cmd_op_e          cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;

   modport master (
      output cmd_valid, cmd_op, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/counter_cmd_responder.sv
// ---------------------------------------------------------------------------
// counter_cmd_responder
// RTL responder for the counter command protocol. It accepts one command per
// handshake on the command channel and keeps a WIDTH-bit count. A GET command
// returns the count on the response channel. While a GET response is waiting
// to be consumed, the responder does not accept further commands.
// Ports:
//   clk        : single clock; all state is updated on posedge
//   rst        : asynchronous, active-high reset
//   auto_cycle : increments the count on every clock in which no command is
//                accepted
//   bus        : command/response channels (slave modport)
//   count      : live count register
//   wrap       : one-cycle pulse after an increment from all-ones to zero
// ---------------------------------------------------------------------------
module counter_cmd_responder
   import counter_cmd_pkg::*;
#(
   parameter int               WIDTH     = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    auto_cycle,
   counter_cmd_responder_if.slave  bus,
   output logic [WIDTH-1:0]        count,
   output logic                    wrap
);

   state_e           state_q,     state_d;
   logic [WIDTH-1:0] count_q,     count_d;
   logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             wrap_q,      wrap_d;
   logic             accept;
   logic             incr;

   // Next-state logic for the counter, the response slot and the FSM.
   // An accepted command always takes priority over auto_cycle, and only one
   // increment can happen per clock. So CYCLE and auto_cycle together still
   // give +1. Accepting a GET also blocks auto_cycle in that clock.
   // cmd_ready and rsp_valid are computed from the next state so that both
   // leave this module as flop outputs. cmd_ready_q is also cleared in reset,
   // which keeps the responder closed for one clock after reset is released.
   always_comb begin
      accept      = bus.cmd_valid & cmd_ready_q;
      incr        = 1'b0;
      count_d     = count_q;
      rsp_data_d  = rsp_data_q;
      state_d     = state_q;

      if (accept) begin
         case (bus.cmd_op)
            CMD_RESET: count_d    = RESET_VAL;
            CMD_LOAD:  count_d    = bus.cmd_data;
            CMD_CYCLE: incr       = 1'b1;
            CMD_GET:   rsp_data_d = count_q;
         endcase
      end else if (auto_cycle) begin
         incr = 1'b1;
      end

      if (incr) begin
         count_d = count_q + 1'b1;
      end
      wrap_d = incr & (&count_q);

      case (state_q)
         IDLE: if (accept && (bus.cmd_op == CMD_GET)) state_d = RESP;
         RESP: if (bus.rsp_ready)                      state_d = IDLE;
      endcase

      cmd_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
   end

   // State and output registers. Reset clears a pending response at once,
   // without a handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= RESET_VAL;
         rsp_data_q  <= '0;
         rsp_valid_q <= 1'b0;
         cmd_ready_q <= 1'b0;
         wrap_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
         cmd_ready_q <= cmd_ready_d;
         wrap_q      <= wrap_d;
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign count         = count_q;
   assign wrap          = wrap_q;

endmodule

// File: tb/tb_counter_cmd_responder.sv
// ---------------------------------------------------------------------------
// tb_counter_cmd_responder
// Directed bench for counter_cmd_responder. Each stimulus step drives the
// inputs one time unit after a rising edge, so checks at that point see the
// values registered at that edge. A GET pushes its hand-computed response onto
// exp_q. A separate monitor pops from exp_q on every response handshake.
// ---------------------------------------------------------------------------
module tb_counter_cmd_responder;
   import counter_cmd_pkg::*;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             auto_cycle;
   logic [WIDTH-1:0] count;
   logic             wrap;

   int               tests_run    = 0;
   int               tests_failed = 0;
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] mon_exp;

   counter_cmd_responder_if #(.WIDTH(WIDTH)) bus ();

   counter_cmd_responder #(
      .WIDTH     (WIDTH),
      .RESET_VAL (8'h00)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .auto_cycle (auto_cycle),
      .bus        (bus.slave),
      .count      (count),
      .wrap       (wrap)
   );

   always #5 clk = ~clk;

   // Compare a single value and log a mismatch.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Advance to one time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold a command until cmd_ready lets it through, with a bounded wait.
   // For a GET, push the expected response onto exp_q.
   task automatic applyStimulus(input cmd_op_e op, input logic [WIDTH-1:0] data,
                                input logic [WIDTH-1:0] exp_rsp);
      bit accepted;
      accepted      = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = data;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.cmd_ready) begin
            accepted = 1'b1;
            break;
         end
      end
      if (!accepted) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL accept_timeout: op %0d not accepted within 50 cycles", op);
      end else if (op == CMD_GET) begin
         exp_q.push_back(exp_rsp);
      end
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   // Response monitor: every handshake must match the oldest expected GET.
   always @(negedge clk) begin
      if (!rst && bus.rsp_valid && bus.rsp_ready) begin
         if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected_rsp: got 0x%0h, expected no response", bus.rsp_data);
         end else begin
            mon_exp = exp_q.pop_front();
            checkOutput("rsp_data", {24'h0, bus.rsp_data}, {24'h0, mon_exp});
         end
      end
   end

   // Global time limit.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      rst           = 1'b0;
      auto_cycle    = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = CMD_RESET;
      bus.cmd_data  = '0;
      bus.rsp_ready = 1'b1;

      // Power-on reset and release.
      #2 rst = 1'b1;
      repeat (3) tick();
      checkOutput("rst_count",     {24'h0, count}, 32'h00);
      checkOutput("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
      checkOutput("rst_rsp_data",  {24'h0, bus.rsp_data}, 32'h00);
      checkOutput("rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
      checkOutput("rst_wrap",      {31'h0, wrap}, 32'h0);
      rst = 1'b0;
      #1 checkOutput("release_cmd_ready_low", {31'h0, bus.cmd_ready}, 32'h0);
      tick();
      checkOutput("release_cmd_ready_high", {31'h0, bus.cmd_ready}, 32'h1);

      // RESET, LOAD 10, CYCLE x3, GET -> 13. Then a back-to-back GET.
      applyStimulus(CMD_LOAD, 8'h55, 8'h00);
      checkOutput("load_55", {24'h0, count}, 32'h55);
      applyStimulus(CMD_RESET, 8'hAA, 8'h00);
      checkOutput("reset_cmd", {24'h0, count}, 32'h00);
      applyStimulus(CMD_LOAD, 8'd10, 8'h00);
      checkOutput("load_10", {24'h0, count}, 32'd10);
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(CMD_CYCLE, 8'h00, 8'h00);
         checkOutput("cycle", {24'h0, count}, 32'd10 + i);
      end
      applyStimulus(CMD_GET, 8'h00, 8'd13);
      checkOutput("get_rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
      checkOutput("get_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
      checkOutput("get_count",     {24'h0, count}, 32'd13);
      applyStimulus(CMD_GET, 8'h00, 8'd13);

      // Wrap from CYCLE: FE -> FF -> 00, a single-cycle pulse.
      applyStimulus(CMD_LOAD, 8'hFE, 8'h00);
      checkOutput("load_fe_wrap", {31'h0, wrap}, 32'h0);
      applyStimulus(CMD_CYCLE, 8'h00, 8'h00);
      checkOutput("cycle_ff",      {24'h0, count}, 32'hFF);
      checkOutput("cycle_ff_wrap", {31'h0, wrap}, 32'h0);
      applyStimulus(CMD_CYCLE, 8'h00, 8'h00);
      checkOutput("cycle_00",      {24'h0, count}, 32'h00);
      checkOutput("cycle_00_wrap", {31'h0, wrap}, 32'h1);
      tick();
      checkOutput("wrap_one_shot", {31'h0, wrap}, 32'h0);

      // auto_cycle priority: LOAD wins, then idle +1, then CYCLE+auto = +1.
      auto_cycle = 1'b1;
      applyStimulus(CMD_LOAD, 8'd5, 8'h00);
      checkOutput("auto_load_wins", {24'h0, count}, 32'd5);
      tick();
      checkOutput("auto_idle_inc", {24'h0, count}, 32'd6);
      applyStimulus(CMD_CYCLE, 8'h00, 8'h00);
      checkOutput("cycle_plus_auto", {24'h0, count}, 32'd7);
      auto_cycle = 1'b0;
      tick();
      checkOutput("auto_off_hold", {24'h0, count}, 32'd7);

      // Wrap from auto_cycle.
      auto_cycle = 1'b1;
      applyStimulus(CMD_LOAD, 8'hFF, 8'h00);
      checkOutput("auto_load_ff", {24'h0, count}, 32'hFF);
      tick();
      auto_cycle = 1'b0;
      checkOutput("auto_wrap_count", {24'h0, count}, 32'h00);
      checkOutput("auto_wrap_pulse", {31'h0, wrap}, 32'h1);
      tick();
      checkOutput("auto_wrap_clear", {31'h0, wrap}, 32'h0);

      // GET stalled for 4 clocks while auto_cycle runs.
      applyStimulus(CMD_LOAD, 8'h40, 8'h00);
      auto_cycle    = 1'b1;
      bus.rsp_ready = 1'b0;
      applyStimulus(CMD_GET, 8'h00, 8'h40);
      checkOutput("stall_get_count", {24'h0, count}, 32'h40);
      checkOutput("stall_rsp_data",  {24'h0, bus.rsp_data}, 32'h40);
      for (int i = 1; i <= 4; i++) begin
         tick();
         checkOutput("stall_count",     {24'h0, count}, 32'h40 + i);
         checkOutput("stall_rsp_data",  {24'h0, bus.rsp_data}, 32'h40);
         checkOutput("stall_rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
         checkOutput("stall_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
      end
      bus.rsp_ready = 1'b1;
      tick();
      auto_cycle = 1'b0;
      checkOutput("stall_done_count",     {24'h0, count}, 32'h45);
      checkOutput("stall_done_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
      checkOutput("stall_done_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);

      // Reset while a response is pending drops it at once.
      applyStimulus(CMD_LOAD, 8'h33, 8'h00);
      bus.rsp_ready = 1'b0;
      applyStimulus(CMD_GET, 8'h00, 8'h33);
      checkOutput("pending_rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
      rst = 1'b1;
      #1;
      checkOutput("midrst_count",     {24'h0, count}, 32'h00);
      checkOutput("midrst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
      checkOutput("midrst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
      checkOutput("midrst_wrap",      {31'h0, wrap}, 32'h0);
      exp_q.delete();
      tick();
      tick();
      rst           = 1'b0;
      bus.rsp_ready = 1'b1;
      #1 checkOutput("midrst_release_low", {31'h0, bus.cmd_ready}, 32'h0);
      tick();
      checkOutput("midrst_release_high", {31'h0, bus.cmd_ready}, 32'h1);
      checkOutput("midrst_no_rsp",       {31'h0, bus.rsp_valid}, 32'h0);
      applyStimulus(CMD_CYCLE, 8'h00, 8'h00);
      checkOutput("post_rst_cycle", {24'h0, count}, 32'h01);
      applyStimulus(CMD_GET, 8'h00, 8'h01);

      repeat (3) tick();
      checkOutput("scoreboard_drain", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
